// File: rtl/drop_pkg.sv
// Shared types and constants for the baggage-drop sequencing stage.
package drop_pkg;

  localparam int TIME_W          = 16;
  localparam int FRAC_W          = 8;
  localparam int DEF_TICK_DIV    = 4;
  localparam int DEF_HOLD_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_COUNT = 3'd2,
    ST_DROP  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle time ticks; restarts from zero whenever cleared.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TERM);

  // Prescaler next-state: clear wins over counting, wrap at the terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/drop_sequencer.sv
// Turns a computed fall time into a checked, counted-down and held drop command.
module drop_sequencer
  import drop_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIME_W-1:0] t_act,
  input  logic [7:0]        t_lim,
  input  logic              drop_en,
  input  logic              cancel,
  output logic              busy,
  output logic [TIME_W-1:0] countdown,
  output logic              drop_activated,
  output logic              abort
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] t_act_q, t_act_d;
  logic [7:0]        t_lim_q, t_lim_d;
  logic              drop_en_q, drop_en_d;
  logic [TIME_W-1:0] countdown_q, countdown_d;
  logic [7:0]        hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              abort_q, abort_d;
  logic              tick_s;
  logic              counting_s;
  logic [TIME_W-1:0] limit_s;

  assign counting_s = (state_q == ST_COUNT);
  assign limit_s    = {t_lim_q, {FRAC_W{1'b0}}};

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en_i  (counting_s),
    .clr_i (~counting_s),
    .tick_o(tick_s)
  );

  // Sequencer next-state, latching and countdown
  always_comb begin
    state_d     = state_q;
    t_act_d     = t_act_q;
    t_lim_d     = t_lim_q;
    drop_en_d   = drop_en_q;
    countdown_d = countdown_q;
    hold_d      = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          t_act_d   = t_act;
          t_lim_d   = t_lim;
          drop_en_d = drop_en;
          state_d   = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!drop_en_q) begin
          state_d = ST_ABORT;
        end else if (t_act_q > limit_s) begin
          state_d = ST_ABORT;
        end else if (t_act_q == {TIME_W{1'b0}}) begin
          state_d     = ST_DROP;
          countdown_d = '0;
          hold_d      = 8'd0;
        end else begin
          state_d     = ST_COUNT;
          countdown_d = t_act_q;
        end
      end
      ST_COUNT: begin
        // cancel outranks a coincident terminal tick, freezing the countdown
        if (cancel) begin
          state_d = ST_ABORT;
        end else if (tick_s) begin
          countdown_d = countdown_q - 16'd1;
          if (countdown_q == 16'd1) begin
            state_d = ST_DROP;
            hold_d  = 8'd0;
          end else begin
            state_d = ST_COUNT;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DROP: begin
        countdown_d = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_ABORT: begin
        state_d     = ST_IDLE;
        countdown_d = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        countdown_d = '0;
        hold_d      = 8'd0;
      end
    endcase
  end

  // Moore flags decoded from the next state so they register alongside it
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    drop_d  = (state_d == ST_DROP);
    abort_d = (state_d == ST_ABORT);
  end

  // State, latched request and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_act_q     <= '0;
      t_lim_q     <= 8'd0;
      drop_en_q   <= 1'b0;
      countdown_q <= '0;
      hold_q      <= 8'd0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_act_q     <= t_act_d;
      t_lim_q     <= t_lim_d;
      drop_en_q   <= drop_en_d;
      countdown_q <= countdown_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      abort_q     <= abort_d;
    end
  end

  assign busy           = busy_q;
  assign countdown      = countdown_q;
  assign drop_activated = drop_q;
  assign abort          = abort_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Randomised and directed bench for drop_sequencer against a timeline model of each request.
module tb_drop_sequencer;

  localparam int TD   = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] t_act = 16'd0;
  logic [7:0]  t_lim = 8'd0;
  logic        drop_en = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [15:0] countdown;
  logic        drop_activated;
  logic        abort;

  drop_sequencer #(.TICK_DIV(TD), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .t_act(t_act), .t_lim(t_lim),
    .drop_en(drop_en), .cancel(cancel), .busy(busy), .countdown(countdown),
    .drop_activated(drop_activated), .abort(abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int e = 0;

  // Model of the current request as a timeline: accept edge, drop edge, cancel edge, idle edge
  bit m_valid = 1'b0;
  bit m_abort = 1'b0;
  bit m_cancel = 1'b0;
  int m_a = 0, m_d = 0, m_c = 0, m_t = 0;
  int m_idle = -1;

  task automatic model_edge(input int ed);
    if (ed > m_idle && start) begin
      m_valid  = 1'b1;
      m_a      = ed;
      m_t      = int'(t_act);
      m_cancel = 1'b0;
      if (!drop_en || int'(t_act) > int'(t_lim) * 256) begin
        m_abort = 1'b1;
        m_idle  = ed + 2;
      end else begin
        m_abort = 1'b0;
        m_d     = ed + 1 + m_t * TD;
        m_idle  = m_d + HOLD;
      end
    end else if (m_valid && !m_abort && !m_cancel && ed < m_idle && cancel &&
                 m_t > 0 && ed >= m_a + 2 && ed <= m_d) begin
      m_cancel = 1'b1;
      m_c      = ed;
      m_idle   = ed + 1;
    end
  endtask

  function automatic logic [18:0] expv(input int ed);
    int cd;
    if (!m_valid || ed >= m_idle || ed < m_a) return 19'd0;
    if (ed == m_a) return {3'b100, 16'd0};
    if (m_abort) return {3'b101, 16'd0};
    if (m_cancel && ed == m_c) begin
      cd = m_t - (m_c - m_a - 2) / TD;
      return {3'b101, 16'(cd)};
    end
    if (ed < m_d) begin
      cd = m_t - (ed - m_a - 1) / TD;
      return {3'b100, 16'(cd)};
    end
    return {3'b110, 16'd0};
  endfunction

  function automatic logic [18:0] obs();
    return {busy, drop_activated, abort, countdown};
  endfunction

  task automatic tick();
    @(posedge clk);
    e++;
    if (!rst) model_edge(e);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idle  = -1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if (obs() !== 19'd0) begin
      fails++;
      $display("FAIL reset_state got %h expected %h", obs(), 19'd0);
    end
    rst = 1'b0;
    model_reset();
    tick();
    tests++;
    if (obs() !== 19'd0) begin
      fails++;
      $display("FAIL after_reset got %h expected %h", obs(), 19'd0);
    end
  endtask

  task automatic test_count();
    int a, first, ndrop, nab;
    first = -1; ndrop = 0; nab = 0;
    t_act = 16'h0003; t_lim = 8'd1; drop_en = 1'b1; start = 1'b1;
    tick();
    a = e;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL count_seq edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
      if (drop_activated) begin
        if (first < 0) first = e;
        ndrop++;
      end
      if (abort) nab++;
    end
    tests++;
    if (first - a !== 13 || ndrop !== 8 || nab !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL count_timing got first=%0d n=%0d ab=%0d expected 13 8 0", first - a, ndrop, nab);
    end
  endtask

  task automatic test_limit();
    int a;
    t_act = 16'h0201; t_lim = 8'd2; drop_en = 1'b1; start = 1'b1;
    tick();
    a = e;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL limit_over edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
      if (e == a + 1) begin
        tests++;
        if (abort !== 1'b1 || drop_activated !== 1'b0) begin
          fails++;
          $display("FAIL limit_abort got %b expected 1", abort);
        end
      end
    end
    t_act = 16'h0200; start = 1'b1;
    tick();
    a = e;
    start = 1'b0;
    tick();
    tests++;
    if (countdown !== 16'h0200 || busy !== 1'b1 || abort !== 1'b0) begin
      fails++;
      $display("FAIL limit_equal got cd=%h busy=%b expected 0200 1", countdown, busy);
    end
    for (int i = 0; i < 6; i++) begin
      cancel = (i == 5);
      tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL limit_cancel edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
    end
    cancel = 1'b0;
    tick();
  endtask

  task automatic test_abort_zero();
    int a, first, ndrop, nab;
    nab = 0;
    t_act = 16'h0001; t_lim = 8'd5; drop_en = 1'b0; start = 1'b1;
    tick();
    a = e;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (abort) nab++;
      tests++;
      if (obs() !== expv(e) || (e == a + 1 && abort !== 1'b1)) begin
        fails++;
        $display("FAIL en_off edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
    end
    tests++;
    if (nab !== 1) begin
      fails++;
      $display("FAIL en_off_pulses got %0d expected 1", nab);
    end
    t_act = 16'h0000; drop_en = 1'b1; start = 1'b1;
    first = -1; ndrop = 0;
    tick();
    a = e;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests++;
      if (obs() !== expv(e) || (drop_activated && countdown !== 16'd0)) begin
        fails++;
        $display("FAIL zero_time edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
      if (drop_activated) begin
        if (first < 0) first = e;
        ndrop++;
      end
    end
    tests++;
    if (first - a !== 1 || ndrop !== 8) begin
      fails++;
      $display("FAIL zero_timing got first=%0d n=%0d expected 1 8", first - a, ndrop);
    end
  endtask

  task automatic test_cancel();
    int a;
    t_act = 16'h0010; t_lim = 8'd1; drop_en = 1'b1; start = 1'b1;
    tick();
    a = e;
    start = 1'b0;
    while (e < a + 13) begin
      cancel = (e == a + 12);
      tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL cancel_seq edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
    end
    cancel = 1'b0;
    tests++;
    if (abort !== 1'b1 || countdown !== 16'd14 || drop_activated !== 1'b0) begin
      fails++;
      $display("FAIL cancel_freeze got ab=%b cd=%0d expected 1 14", abort, countdown);
    end
    tick();
    tests++;
    if (obs() !== 19'd0) begin
      fails++;
      $display("FAIL cancel_clear got %h expected %h", obs(), 19'd0);
    end
  endtask

  task automatic test_reset_mid();
    int a, first;
    first = -1;
    t_act = 16'h0010; t_lim = 8'd1; drop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (obs() !== 19'd0) begin
      fails++;
      $display("FAIL reset_count got %h expected %h", obs(), 19'd0);
    end
    tick();
    rst = 1'b0;
    tick();
    t_act = 16'h0002; start = 1'b1;
    tick();
    a = e;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL reset_restart edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
      if (drop_activated && first < 0) first = e;
    end
    tests++;
    if (first - a !== 9) begin
      fails++;
      $display("FAIL restart_drop got %0d expected 9", first - a);
    end
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (obs() !== 19'd0) begin
      fails++;
      $display("FAIL reset_drop got %h expected %h", obs(), 19'd0);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int a, rises;
    logic prev;
    rises = 0; prev = 1'b0;
    t_act = 16'h0001; t_lim = 8'd1; drop_en = 1'b1; start = 1'b1;
    tick();
    a = e;
    for (int i = 0; i < 42; i++) begin
      if (i > 0) tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL b2b edge+%0d got %h expected %h", e - a, obs(), expv(e));
      end
      if (drop_activated && !prev) rises++;
      prev = drop_activated;
    end
    start = 1'b0;
    tests++;
    if (rises !== 3) begin
      fails++;
      $display("FAIL b2b_count got %0d expected 3", rises);
    end
    for (int k = 0; k < 40 && busy; k++) tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 5) == 0);
      drop_en = ($urandom_range(0, 7) != 0);
      cancel  = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) begin
        t_act = 16'($urandom_range(0, 12));
        t_lim = 8'($urandom_range(0, 3));
      end else if (r < 8) begin
        t_lim = 8'($urandom_range(0, 2));
        t_act = 16'(int'(t_lim) * 256 + int'($urandom_range(0, 1)));
      end else begin
        t_act = 16'($urandom_range(16'h0100, 16'h0FFF));
        t_lim = 8'($urandom_range(0, int'(t_act[15:8]) - 1));
      end
      tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL random cycle %0d got %h expected %h", i, obs(), expv(e));
      end
    end
    start = 1'b0;
    for (int k = 0; k < 12000 && busy; k++) begin
      cancel = ($urandom_range(0, 39) == 0);
      tick();
      tests++;
      if (obs() !== expv(e)) begin
        fails++;
        $display("FAIL random_drain got %h expected %h", obs(), expv(e));
      end
    end
    cancel = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL random_timeout got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_limit();
    test_abort_zero();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
